// File: rtl/i2s_tx.sv
// I2S transmitter: serialises 24-bit L/R pairs MSB-first, one bit after each WS edge.
// Generates its own SCK/WS and keeps a one-pair holding buffer with underrun/overrun flags.
module i2s_tx #(
   parameter int unsigned DIV_CLK   = 28,
   parameter int unsigned SLOT_BITS = 32,
   parameter int unsigned DATA_W    = 24
) (
   input  logic              clk,
   input  logic              Reset_n,
   input  logic [DATA_W-1:0] L_Data_in,
   input  logic [DATA_W-1:0] R_Data_in,
   input  logic              Sample_Valid,
   input  logic              Enable,
   output logic              SCK_output,
   output logic              WS_output,
   output logic              SD_output,
   output logic              Sample_Ack,
   output logic              Underrun,
   output logic              Overrun,
   output logic [15:0]       Underrun_cnt
);

   localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
   localparam int unsigned SCK_W      = $clog2(DIV_CLK);
   localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

   localparam logic [SCK_W-1:0] SCK_LAST     = SCK_W'(DIV_CLK - 1);
   localparam logic [SCK_W-1:0] SCK_HALF     = SCK_W'(DIV_CLK / 2);
   localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] SLOT         = BIT_W'(SLOT_BITS);
   localparam logic [BIT_W-1:0] L_LAST       = BIT_W'(DATA_W);
   localparam logic [BIT_W-1:0] L_SHIFT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] R_FIRST      = BIT_W'(SLOT_BITS + 1);
   localparam logic [BIT_W-1:0] R_LAST       = BIT_W'(SLOT_BITS + DATA_W);
   localparam logic [BIT_W-1:0] R_SHIFT_LAST = BIT_W'(SLOT_BITS + DATA_W - 1);

   logic [SCK_W-1:0]  sck_cnt_q, sck_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] shift_l_q, shift_l_d, shift_r_q, shift_r_d;
   logic              tx_en_q, tx_en_d;
   logic              ack_q, ack_d, underrun_q, underrun_d, overrun_q, overrun_d;
   logic [15:0]       underrun_cnt_q, underrun_cnt_d;

   logic sck_last, fb, consume, l_win, r_win, l_shift, r_shift;

   assign sck_last = (sck_cnt_q == SCK_LAST);
   assign fb       = sck_last && (bit_cnt_q == BIT_LAST);
   assign consume  = fb && Enable && hold_full_q;
   assign l_win    = (bit_cnt_q != '0) && (bit_cnt_q <= L_LAST);
   assign r_win    = (bit_cnt_q >= R_FIRST) && (bit_cnt_q <= R_LAST);
   assign l_shift  = (bit_cnt_q != '0) && (bit_cnt_q <= L_SHIFT_LAST);
   assign r_shift  = (bit_cnt_q >= R_FIRST) && (bit_cnt_q <= R_SHIFT_LAST);

   always_comb begin
      sck_cnt_d      = sck_last ? '0 : sck_cnt_q + 1'b1;
      bit_cnt_d      = bit_cnt_q;
      hold_l_d       = hold_l_q;
      hold_r_d       = hold_r_q;
      hold_full_d    = hold_full_q;
      shift_l_d      = shift_l_q;
      shift_r_d      = shift_r_q;
      tx_en_d        = tx_en_q;
      ack_d          = consume;
      underrun_d     = fb && Enable && !hold_full_q;
      overrun_d      = Sample_Valid && hold_full_q && !consume;
      underrun_cnt_d = underrun_cnt_q;

      if (sck_last) begin
         bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      end

      // New data always wins; a coincident consume still sends the old pair.
      if (Sample_Valid) begin
         hold_l_d    = L_Data_in;
         hold_r_d    = R_Data_in;
         hold_full_d = 1'b1;
      end else if (consume) begin
         hold_full_d = 1'b0;
      end

      if (fb) begin
         tx_en_d   = Enable;
         shift_l_d = consume ? hold_l_q : '0;
         shift_r_d = consume ? hold_r_q : '0;
      end else if (sck_last) begin
         if (l_shift) shift_l_d = {shift_l_q[DATA_W-2:0], 1'b0};
         if (r_shift) shift_r_d = {shift_r_q[DATA_W-2:0], 1'b0};
      end

      if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
         underrun_cnt_d = underrun_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sck_cnt_q      <= '0;
         bit_cnt_q      <= '0;
         hold_l_q       <= '0;
         hold_r_q       <= '0;
         hold_full_q    <= 1'b0;
         shift_l_q      <= '0;
         shift_r_q      <= '0;
         tx_en_q        <= 1'b0;
         ack_q          <= 1'b0;
         underrun_q     <= 1'b0;
         overrun_q      <= 1'b0;
         underrun_cnt_q <= '0;
      end else begin
         sck_cnt_q      <= sck_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         hold_l_q       <= hold_l_d;
         hold_r_q       <= hold_r_d;
         hold_full_q    <= hold_full_d;
         shift_l_q      <= shift_l_d;
         shift_r_q      <= shift_r_d;
         tx_en_q        <= tx_en_d;
         ack_q          <= ack_d;
         underrun_q     <= underrun_d;
         overrun_q      <= overrun_d;
         underrun_cnt_q <= underrun_cnt_d;
      end
   end

   assign SCK_output   = (sck_cnt_q >= SCK_HALF);
   assign WS_output    = (bit_cnt_q >= SLOT);
   assign SD_output    = tx_en_q && ((l_win && shift_l_q[DATA_W-1]) ||
                                     (r_win && shift_r_q[DATA_W-1]));
   assign Sample_Ack   = ack_q;
   assign Underrun     = underrun_q;
   assign Overrun      = overrun_q;
   assign Underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: captures whole frames at SCK rising points and compares
// against hand-built frame images, plus pulse and counter checks.
module tb_i2s_tx;

   localparam int DIV    = 28;
   localparam int FRAME  = 64 * DIV;
   localparam int LAST_S = 63 * DIV + 14;
   localparam int BUDGET = 2 * FRAME + 16;

   logic        clk = 1'b0;
   logic        Reset_n;
   logic [23:0] L_Data_in, R_Data_in;
   logic        Sample_Valid, Enable;
   logic        SCK_output, WS_output, SD_output;
   logic        Sample_Ack, Underrun, Overrun;
   logic [15:0] Underrun_cnt;

   int checks = 0;
   int errors = 0;
   int ack_seen = 0, und_seen = 0, ovr_seen = 0;
   int exp_ucnt = 0;

   i2s_tx #(.DIV_CLK(28), .SLOT_BITS(32), .DATA_W(24)) dut (
      .clk          (clk),
      .Reset_n      (Reset_n),
      .L_Data_in    (L_Data_in),
      .R_Data_in    (R_Data_in),
      .Sample_Valid (Sample_Valid),
      .Enable       (Enable),
      .SCK_output   (SCK_output),
      .WS_output    (WS_output),
      .SD_output    (SD_output),
      .Sample_Ack   (Sample_Ack),
      .Underrun     (Underrun),
      .Overrun      (Overrun),
      .Underrun_cnt (Underrun_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (Sample_Ack === 1'b1) ack_seen++;
      if (Underrun === 1'b1) und_seen++;
      if (Overrun === 1'b1) ovr_seen++;
   end

   function automatic logic [63:0] frame_img(input logic [23:0] l, input logic [23:0] r);
      return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
   endfunction

   // Called at a negedge; Sample_Valid is high for exactly the current cycle.
   task automatic pulse_valid(input logic [23:0] l, input logic [23:0] r);
      L_Data_in    = l;
      R_Data_in    = r;
      Sample_Valid = 1'b1;
      @(negedge clk);
      Sample_Valid = 1'b0;
   endtask

   // Returns at the negedge of the first cycle of a frame (just after WS falls).
   task automatic wait_fs();
      logic prev;
      bit   found;
      int   n;
      prev  = WS_output;
      found = 1'b0;
      n     = 0;
      while (!found && n < BUDGET) begin
         @(negedge clk);
         n++;
         if (prev === 1'b1 && WS_output === 1'b0) found = 1'b1;
         prev = WS_output;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_frame_start: no WS falling edge within %0d cycles", BUDGET);
      end
   endtask

   // Entered at frame cycle 0; samples SD/WS at each SCK rise, optionally strobing a
   // new pair at strobe_cyc and dropping Enable at drop_cyc.
   task automatic capture(input int strobe_cyc, input logic [23:0] sl, input logic [23:0] sr,
                          input int drop_cyc, output logic [63:0] sd, output logic [63:0] ws,
                          output bit sck_ok);
      sd     = '0;
      ws     = '0;
      sck_ok = 1'b1;
      for (int c = 0; c <= LAST_S; c++) begin
         if (c == strobe_cyc) begin
            L_Data_in    = sl;
            R_Data_in    = sr;
            Sample_Valid = 1'b1;
         end else begin
            Sample_Valid = 1'b0;
         end
         if (c == drop_cyc) Enable = 1'b0;
         if (SCK_output !== ((c % DIV) >= 14)) sck_ok = 1'b0;
         if ((c % DIV) == 14) begin
            sd[63 - c / DIV] = SD_output;
            ws[63 - c / DIV] = WS_output;
         end
         if (c < LAST_S) @(negedge clk);
      end
      Sample_Valid = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n      = 1'b0;
      Enable       = 1'b0;
      Sample_Valid = 1'b0;
      L_Data_in    = '0;
      R_Data_in    = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({SCK_output, WS_output, SD_output} !== 3'b000) begin
         errors++;
         $display("FAIL reset_bus: got %b expected 000", {SCK_output, WS_output, SD_output});
      end
      checks++;
      if ({Sample_Ack, Underrun, Overrun} !== 3'b000) begin
         errors++;
         $display("FAIL reset_pulses: got %b expected 000", {Sample_Ack, Underrun, Overrun});
      end
      checks++;
      if (Underrun_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL reset_ucnt: got %h expected 0000", Underrun_cnt);
      end
      Reset_n  = 1'b1;
      exp_ucnt = 0;
   endtask

   task automatic test_basic();
      logic [63:0] sd, ws;
      bit          sck_ok;
      int          a0;
      a0     = ack_seen;
      Enable = 1'b1;
      @(negedge clk);
      pulse_valid(24'hA5A5A5, 24'h3C3C3C);
      wait_fs();
      checks++;
      if ({Sample_Ack, Underrun} !== 2'b10) begin
         errors++;
         $display("FAIL basic_ack: ack/underrun %b expected 10", {Sample_Ack, Underrun});
      end
      capture(-1, '0, '0, -1, sd, ws, sck_ok);
      checks++;
      if (sd !== frame_img(24'hA5A5A5, 24'h3C3C3C)) begin
         errors++;
         $display("FAIL basic_sd: got %h expected %h", sd, frame_img(24'hA5A5A5, 24'h3C3C3C));
      end
      checks++;
      if (ws !== 64'h00000000FFFFFFFF) begin
         errors++;
         $display("FAIL basic_ws: got %h expected 00000000ffffffff", ws);
      end
      checks++;
      if (sck_ok !== 1'b1) begin
         errors++;
         $display("FAIL basic_sck: shape ok=%0d expected 1", sck_ok);
      end
      checks++;
      if (ack_seen - a0 !== 1) begin
         errors++;
         $display("FAIL basic_ack_count: got %0d expected 1", ack_seen - a0);
      end
   endtask

   task automatic test_underrun();
      logic [63:0] sd, ws;
      bit          sck_ok;
      int          u0;
      u0 = und_seen;
      for (int k = 0; k < 3; k++) begin
         wait_fs();
         exp_ucnt++;
         checks++;
         if (Underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_pulse[%0d]: got %b expected 1", k, Underrun);
         end
         capture(-1, '0, '0, -1, sd, ws, sck_ok);
         checks++;
         if (sd !== 64'h0) begin
            errors++;
            $display("FAIL underrun_sd[%0d]: got %h expected 0", k, sd);
         end
      end
      checks++;
      if (und_seen - u0 !== 3) begin
         errors++;
         $display("FAIL underrun_count: got %0d expected 3", und_seen - u0);
      end
      checks++;
      if (Underrun_cnt !== 16'd3) begin
         errors++;
         $display("FAIL underrun_cnt: got %0d expected 3", Underrun_cnt);
      end
   endtask

   task automatic test_overrun();
      logic [63:0] sd, ws;
      bit          sck_ok;
      int          a0, o0;
      a0 = ack_seen;
      o0 = ovr_seen;
      wait_fs();
      exp_ucnt++;
      pulse_valid(24'hC0FFEE, 24'h123456);
      pulse_valid(24'h0F0F0F, 24'hF0F0F1);
      checks++;
      if (Overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_pulse: got %b expected 1", Overrun);
      end
      wait_fs();
      checks++;
      if (Sample_Ack !== 1'b1) begin
         errors++;
         $display("FAIL overrun_ack: got %b expected 1", Sample_Ack);
      end
      capture(-1, '0, '0, -1, sd, ws, sck_ok);
      checks++;
      if (sd !== frame_img(24'h0F0F0F, 24'hF0F0F1)) begin
         errors++;
         $display("FAIL overrun_sd: got %h expected %h", sd, frame_img(24'h0F0F0F, 24'hF0F0F1));
      end
      checks++;
      if ((ack_seen - a0 !== 1) || (ovr_seen - o0 !== 1)) begin
         errors++;
         $display("FAIL overrun_counts: acks %0d overruns %0d expected 1 1",
                  ack_seen - a0, ovr_seen - o0);
      end
      checks++;
      if (Underrun_cnt !== 16'(exp_ucnt)) begin
         errors++;
         $display("FAIL overrun_ucnt: got %0d expected %0d", Underrun_cnt, exp_ucnt);
      end
   endtask

   task automatic test_coincident();
      logic [63:0] sd, ws;
      bit          sck_ok;
      int          o0;
      o0 = ovr_seen;
      wait_fs();
      exp_ucnt++;
      pulse_valid(24'h111111, 24'h222222);
      repeat (FRAME - 2) @(negedge clk);
      pulse_valid(24'h333333, 24'h444444);
      checks++;
      if ({Sample_Ack, Overrun} !== 2'b10) begin
         errors++;
         $display("FAIL coinc_ack: ack/overrun %b expected 10", {Sample_Ack, Overrun});
      end
      capture(-1, '0, '0, -1, sd, ws, sck_ok);
      checks++;
      if (sd !== frame_img(24'h111111, 24'h222222)) begin
         errors++;
         $display("FAIL coinc_old: got %h expected %h", sd, frame_img(24'h111111, 24'h222222));
      end
      wait_fs();
      checks++;
      if (Sample_Ack !== 1'b1) begin
         errors++;
         $display("FAIL coinc_ack2: got %b expected 1", Sample_Ack);
      end
      capture(-1, '0, '0, -1, sd, ws, sck_ok);
      checks++;
      if (sd !== frame_img(24'h333333, 24'h444444)) begin
         errors++;
         $display("FAIL coinc_new: got %h expected %h", sd, frame_img(24'h333333, 24'h444444));
      end
      checks++;
      if (ovr_seen - o0 !== 0) begin
         errors++;
         $display("FAIL coinc_overrun: got %0d expected 0", ovr_seen - o0);
      end
   endtask

   task automatic test_enable();
      logic [63:0] sd, ws;
      bit          sck_ok;
      wait_fs();
      exp_ucnt++;
      pulse_valid(24'hDEADBE, 24'h5A5A5A);
      wait_fs();
      capture(3, 24'h654321, 24'h13579B, 10 * DIV + 5, sd, ws, sck_ok);
      checks++;
      if (sd !== frame_img(24'hDEADBE, 24'h5A5A5A)) begin
         errors++;
         $display("FAIL enable_finish: got %h expected %h", sd, frame_img(24'hDEADBE, 24'h5A5A5A));
      end
      wait_fs();
      checks++;
      if ({Sample_Ack, Underrun} !== 2'b00) begin
         errors++;
         $display("FAIL disabled_pulses: ack/underrun %b expected 00", {Sample_Ack, Underrun});
      end
      capture(-1, '0, '0, -1, sd, ws, sck_ok);
      checks++;
      if (sd !== 64'h0) begin
         errors++;
         $display("FAIL disabled_sd: got %h expected 0", sd);
      end
      Enable = 1'b1;
      wait_fs();
      checks++;
      if (Sample_Ack !== 1'b1) begin
         errors++;
         $display("FAIL reenable_ack: got %b expected 1", Sample_Ack);
      end
      capture(-1, '0, '0, -1, sd, ws, sck_ok);
      checks++;
      if (sd !== frame_img(24'h654321, 24'h13579B)) begin
         errors++;
         $display("FAIL reenable_sd: got %h expected %h", sd, frame_img(24'h654321, 24'h13579B));
      end
      checks++;
      if (Underrun_cnt !== 16'(exp_ucnt)) begin
         errors++;
         $display("FAIL enable_ucnt: got %0d expected %0d", Underrun_cnt, exp_ucnt);
      end
   endtask

   task automatic test_loopback();
      logic [63:0] sd, ws;
      bit          sck_ok;
      for (int k = 0; k < 4; k++) begin
         wait_fs();
         if (k == 0) exp_ucnt++;
         capture(5, 24'h800001, 24'h7FFFFE, -1, sd, ws, sck_ok);
         if (k > 0) begin
            checks++;
            if (sd[62:39] !== 24'h800001) begin
               errors++;
               $display("FAIL loop_left[%0d]: got %h expected 800001", k, sd[62:39]);
            end
            checks++;
            if (sd[30:7] !== 24'h7FFFFE) begin
               errors++;
               $display("FAIL loop_right[%0d]: got %h expected 7ffffe", k, sd[30:7]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      checks++;
      if (Underrun_cnt !== 16'(exp_ucnt)) begin
         errors++;
         $display("FAIL sat_pre: got %0d expected %0d", Underrun_cnt, exp_ucnt);
      end
      wait_fs();
      force dut.underrun_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.underrun_cnt_q;
      @(negedge clk);
      checks++;
      if (Underrun_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_forced: got %h expected ffff", Underrun_cnt);
      end
      wait_fs();
      checks++;
      if ({Underrun, Underrun_cnt} !== {1'b1, 16'hFFFF}) begin
         errors++;
         $display("FAIL sat_hold: underrun %b cnt %h expected 1 ffff", Underrun, Underrun_cnt);
      end
   endtask

   task automatic test_reset_mid();
      repeat (1000) @(negedge clk);
      pulse_valid(24'hABCDEF, 24'hFEDCBA);
      Reset_n = 1'b0;
      #1;
      checks++;
      if ({SCK_output, WS_output, SD_output, Sample_Ack, Underrun, Overrun} !== 6'b0) begin
         errors++;
         $display("FAIL midreset_out: got %b expected 000000",
                  {SCK_output, WS_output, SD_output, Sample_Ack, Underrun, Overrun});
      end
      checks++;
      if (Underrun_cnt !== 16'h0) begin
         errors++;
         $display("FAIL midreset_ucnt: got %h expected 0000", Underrun_cnt);
      end
      @(negedge clk);
      Reset_n  = 1'b1;
      Enable   = 1'b1;
      exp_ucnt = 0;
      wait_fs();
      exp_ucnt++;
      checks++;
      if ({Sample_Ack, Underrun} !== 2'b01) begin
         errors++;
         $display("FAIL midreset_lost: ack/underrun %b expected 01", {Sample_Ack, Underrun});
      end
      checks++;
      if (Underrun_cnt !== 16'(exp_ucnt)) begin
         errors++;
         $display("FAIL midreset_cnt: got %0d expected %0d", Underrun_cnt, exp_ucnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_overrun();
      test_coincident();
      test_enable();
      test_loopback();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- I2S transmitter stage directly downstream of the MEMS-microphone I2S receiver.
- Takes 24-bit left/right sample pairs, once per audio frame, and serialises them MSB-first onto an I2S bus toward a DAC/codec.
- Generates its own SCK/WS with the same divider scheme and frame format as the receiver (64 SCK per frame, 24 data bits per 32-bit slot, MSB one bit after the WS edge), so a receiver→tx loopback is phase-compatible.
- Holds one sample pair in a holding buffer and reports underrun/overrun.

Parameters:
DIV_CLK, 28, clk cycles per SCK period; even, >=4
SLOT_BITS, 32, SCK periods per channel slot; frame = 2*SLOT_BITS
DATA_W, 24, sample width; DATA_W <= SLOT_BITS-1

Ports:
clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
L_Data_in  in  DATA_W  left sample
R_Data_in  in  DATA_W  right sample
Sample_Valid  in  1  1-cycle strobe: L/R_Data_in valid this cycle
Enable  in  1  transmit enable; sampled only at frame boundary
SCK_output  out  1  I2S serial clock
WS_output  out  1  word select, 0 = left, 1 = right
SD_output  out  1  serial data to DAC
Sample_Ack  out  1  1-cycle pulse: holding buffer consumed into shifters
Underrun  out  1  1-cycle pulse: frame started enabled with empty buffer
Overrun  out  1  1-cycle pulse: Sample_Valid overwrote an unconsumed pair
Underrun_cnt  out  16  saturating underrun count

Behaviour:
- Reset is asynchronous, active-low, on Reset_n; clock is clk. All state clears on reset: sck_cnt=0, bit_cnt=0, hold regs=0, hold_full=0, shift regs=0, tx_en=0, all pulse outputs 0, Underrun_cnt=0.
- Counters:
  - sck_cnt counts 0..DIV_CLK-1 and wraps.
  - bit_cnt advances when sck_cnt==DIV_CLK-1 and wraps 2*SLOT_BITS-1 → 0.
  - Counters free-run regardless of Enable.
- Clock outputs:
  - SCK_output = (sck_cnt >= DIV_CLK/2): low first half, high second half. SD changes near the falling edge and is stable at the rising edge.
  - WS_output = (bit_cnt >= SLOT_BITS). Both are pure decodes of the counter registers.
- Frame boundary tick (FB): sck_cnt==DIV_CLK-1 and bit_cnt==2*SLOT_BITS-1, i.e. the cycle the counters wrap to 0.
- At FB:
  - tx_en <= Enable.
  - If Enable=1 and hold_full=1: shift_l/shift_r <= hold, hold_full cleared, Sample_Ack=1 next cycle.
  - If Enable=1 and hold_full=0: shifters <= 0, Underrun=1 next cycle, Underrun_cnt += 1, saturating at 16'hFFFF.
  - If Enable=0: shifters <= 0; no Ack, no Underrun; hold contents retained.
- Serialisation:
  - SD_output = shift_l[DATA_W-1] when bit_cnt in 1..DATA_W.
  - SD_output = shift_r[DATA_W-1] when bit_cnt in SLOT_BITS+1..SLOT_BITS+DATA_W.
  - SD_output = 0 at all other times, and whenever tx_en=0.
  - shift_l shifts left by 1 (zero fill) at sck_cnt==DIV_CLK-1 when bit_cnt in 1..DATA_W-1; shift_r likewise for SLOT_BITS+1..SLOT_BITS+DATA_W-1.
- Holding buffer:
  - Sample_Valid=1 writes hold_l/hold_r from the inputs and sets hold_full.
  - If hold_full was already 1 and FB is not consuming it that cycle, Overrun pulses next cycle (new data wins).
  - Sample_Valid coincident with a consuming FB: the shifters take the OLD hold contents, hold takes the new pair, hold_full stays 1, no Overrun.
- After reset, the first frame transmits zeros; the first possible load is at the end of frame 0.
- Enable changes mid-frame take effect only at the next FB; the current frame completes unchanged.
- Reset mid-frame: outputs go to reset values immediately; the hold pair is lost.

Test Plan:
- Reset, then Enable=1, Sample_Valid with L=24'hA5A5A5, R=24'h3C3C3C before the first FB → after FB, Sample_Ack pulse once; SD over bits 1..24 = A5A5A5 MSB-first, bits 33..56 = 3C3C3C; SD=0 at bits 0, 25..32, 57..63; WS toggles every 32*28=896 clk; SCK period 28 clk, high 14.
- Enable=1, no Sample_Valid for 3 frames → 3 Underrun pulses, Underrun_cnt=3, SD all zero.
- Two Sample_Valid strobes (pair A, then pair B) within one frame → one Overrun pulse; the next frame transmits B; one Sample_Ack.
- Sample_Valid asserted exactly on the FB cycle with hold_full=1 (pair A held, new pair B) → frame sends A; B remains held and is sent the following frame; no Overrun.
- Enable dropped at bit_cnt=10 → current frame finishes sending its data; next frame SD=0, no Ack/Underrun, hold retained; re-enable → the held pair is sent.
- Loopback of i2s_tx into the receiver (same DIV_CLK) with Sample_Valid of L=24'h800001, R=24'h7FFFFE every frame → receiver L_Data/R_Data equal those values; force Underrun_cnt to 16'hFFFF and underrun once more → it stays at FFFF.
